// File: rtl/pipe_exec_ctrl_pkg.sv
// Shared definitions for the execution-mode controller.
// Holds the UART command byte values and the controller state encoding so the
// debug unit, the controller and any bench agree on the same numbers.
package pipe_exec_ctrl_pkg;

    localparam logic [7:0] CMD_CONT = 8'h63;  // 'c' : continuous run
    localparam logic [7:0] CMD_STEP = 8'h73;  // 's' : enter step mode
    localparam logic [7:0] CMD_NEXT = 8'h6E;  // 'n' : advance one step

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_MODE       = 3'd1,
        ST_RUN        = 3'd2,
        ST_STEP_WAIT  = 3'd3,
        ST_STEP_PULSE = 3'd4,
        ST_DRAIN      = 3'd5,
        ST_DONE       = 3'd6
    } exec_state_e;

    // The pipeline advances only in these states.
    function automatic logic is_enable_state(input exec_state_e s);
        return (s == ST_RUN) || (s == ST_STEP_PULSE) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/pipe_exec_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clock_i  : clock
//   reset_i  : synchronous active-high reset (value -> 0)
//   clear_i  : synchronous clear (value -> 0), wins over inc_i
//   inc_i    : count up by one when not already all-ones
//   value_o  : current count
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] value_o
);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (clear_i) begin
            value_d = '0;
        end else if (inc_i && (value_q != '1)) begin
            value_d = value_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/pipe_exec_ctrl.sv
// Execution-mode controller between the debug unit's UART command path and
// the MIPS pipeline. After a program load (start_i) it waits for a mode byte,
// then either runs continuously or single-steps on 'n' bytes. When HALT is
// fetched it keeps the pipeline enabled for DRAIN_CYCLES more cycles so the
// instructions already in ID/EX/MEM/WB retire, then pulses end_exec_o.
//
// Handshake: there is no ready. start_i and cmd_valid_i are single-cycle
// valid pulses; a byte is consumed only in the states that listen for it and
// silently dropped otherwise. Outputs are Moore (decoded from state_q) except
// ack_step_o, which is a registered pulse in the first STEP_WAIT cycle.
//
// Ports:
//   clock_i, reset_i  : clock, synchronous active-high reset
//   start_i           : program load finished (pulse)
//   cmd_valid_i/cmd_i : received command byte (pulse + data)
//   halt_i            : HALT fetched in IF (level)
//   enable_pipe_o     : pipeline/PC advance enable
//   count_cycles_o    : enable cycles since last start (saturating)
//   ack_step_o        : one step completed (pulse)
//   end_exec_o        : program finished and drained (pulse)
//   busy_o            : not IDLE
//   state_o           : state encoding for debug
module pipe_exec_ctrl
    import pipe_exec_ctrl_pkg::*;
#(
    parameter int N_BITS       = 8,
    parameter int NB_CYCLES    = 32,
    parameter int DRAIN_CYCLES = 4,
    parameter int NB_STATE     = 3
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic                 cmd_valid_i,
    input  logic [N_BITS-1:0]    cmd_i,
    input  logic                 halt_i,
    output logic                 enable_pipe_o,
    output logic [NB_CYCLES-1:0] count_cycles_o,
    output logic                 ack_step_o,
    output logic                 end_exec_o,
    output logic                 busy_o,
    output logic [NB_STATE-1:0]  state_o
);

    localparam int NB_DRAIN = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    // Loaded on entry to DRAIN; DRAIN exits when the counter reads zero, which
    // gives exactly DRAIN_CYCLES cycles in DRAIN.
    localparam logic [NB_DRAIN-1:0] DRAIN_LOAD = NB_DRAIN'(DRAIN_CYCLES - 1);

    exec_state_e         state_q, state_d;
    logic [NB_DRAIN-1:0] drain_q, drain_d;
    logic                ack_q, ack_d;

    logic is_cont;
    logic is_step;
    logic is_next;

    assign is_cont = cmd_valid_i && (cmd_i == N_BITS'(CMD_CONT));
    assign is_step = cmd_valid_i && (cmd_i == N_BITS'(CMD_STEP));
    assign is_next = cmd_valid_i && (cmd_i == N_BITS'(CMD_NEXT));

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        ack_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) state_d = ST_MODE;
            end
            ST_MODE: begin
                if (is_cont)      state_d = ST_RUN;
                else if (is_step) state_d = ST_STEP_WAIT;
            end
            ST_RUN: begin
                if (halt_i) begin
                    state_d = ST_DRAIN;
                    drain_d = DRAIN_LOAD;
                end
            end
            ST_STEP_WAIT: begin
                // halt_i is deliberately not looked at here: the HALT was
                // fetched by a previous step and is handled in STEP_PULSE.
                if (is_next)      state_d = ST_STEP_PULSE;
                else if (is_cont) state_d = ST_RUN;
            end
            ST_STEP_PULSE: begin
                if (halt_i) begin
                    state_d = ST_DRAIN;
                    drain_d = DRAIN_LOAD;
                end else begin
                    state_d = ST_STEP_WAIT;
                    ack_d   = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_q == '0) state_d = ST_DONE;
                else               drain_d = drain_q - NB_DRAIN'(1);
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            drain_q <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            ack_q   <= ack_d;
        end
    end

    assign enable_pipe_o = is_enable_state(state_q);
    assign busy_o        = (state_q != ST_IDLE);
    assign end_exec_o    = (state_q == ST_DONE);
    assign ack_step_o    = ack_q;
    assign state_o       = NB_STATE'(state_q);

    // The count is only cleared by a fresh start so the host can read the
    // final figure after the program ends.
    sat_counter #(
        .WIDTH (NB_CYCLES)
    ) u_cycle_counter (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .clear_i ((state_q == ST_IDLE) && start_i),
        .inc_i   (enable_pipe_o),
        .value_o (count_cycles_o)
    );

endmodule

// File: tb/tb_pipe_exec_ctrl.sv
module tb_pipe_exec_ctrl;
    import pipe_exec_ctrl_pkg::*;

    localparam int DRAIN_CYCLES = 4;

    // ---------------- clock / reset block ----------------
    logic clk;
    logic reset_i;
    logic start_i;
    logic cmd_valid_i;
    logic [7:0] cmd_i;
    logic halt_i;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Full-width instance
    logic        en_o, ack_o, end_o, busy_o;
    logic [31:0] cnt_o;
    logic [2:0]  st_o;
    // Narrow-counter instance, same stimulus, for saturation
    logic        en_s, ack_s, end_s, busy_s;
    logic [3:0]  cnt_s;
    logic [2:0]  st_s;

    pipe_exec_ctrl dut (
        .clock_i        (clk),
        .reset_i        (reset_i),
        .start_i        (start_i),
        .cmd_valid_i    (cmd_valid_i),
        .cmd_i          (cmd_i),
        .halt_i         (halt_i),
        .enable_pipe_o  (en_o),
        .count_cycles_o (cnt_o),
        .ack_step_o     (ack_o),
        .end_exec_o     (end_o),
        .busy_o         (busy_o),
        .state_o        (st_o)
    );

    pipe_exec_ctrl #(.NB_CYCLES(4)) dut_s (
        .clock_i        (clk),
        .reset_i        (reset_i),
        .start_i        (start_i),
        .cmd_valid_i    (cmd_valid_i),
        .cmd_i          (cmd_i),
        .halt_i         (halt_i),
        .enable_pipe_o  (en_s),
        .count_cycles_o (cnt_s),
        .ack_step_o     (ack_s),
        .end_exec_o     (end_s),
        .busy_o         (busy_s),
        .state_o        (st_s)
    );

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic        en;
        logic [31:0] cnt;
        logic [3:0]  cnt_s;
        logic        ack;
        logic        done;
        logic        busy;
        logic [2:0]  st;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Phase-level model: what the controller is doing, how many drain cycles
    // are still owed, and the running enable count (kept unbounded and
    // clipped when compared).
    exec_state_e m_st = ST_IDLE;
    int          m_drain_left = 0;
    longint      m_count = 0;
    bit          m_ack = 0;

    function automatic void model_step();
        bit advancing;
        advancing = (m_st == ST_RUN) || (m_st == ST_STEP_PULSE) || (m_st == ST_DRAIN);
        if (reset_i) begin
            m_st = ST_IDLE; m_count = 0; m_drain_left = 0; m_ack = 0;
            return;
        end
        if (advancing && m_count < 64'hFFFF_FFFF) m_count++;
        m_ack = 0;
        case (m_st)
            ST_IDLE: if (start_i) begin m_st = ST_MODE; m_count = 0; end
            ST_MODE: begin
                if (cmd_valid_i && cmd_i == CMD_CONT)      m_st = ST_RUN;
                else if (cmd_valid_i && cmd_i == CMD_STEP) m_st = ST_STEP_WAIT;
            end
            ST_RUN: if (halt_i) begin m_st = ST_DRAIN; m_drain_left = DRAIN_CYCLES; end
            ST_STEP_WAIT: begin
                if (cmd_valid_i && cmd_i == CMD_NEXT)      m_st = ST_STEP_PULSE;
                else if (cmd_valid_i && cmd_i == CMD_CONT) m_st = ST_RUN;
            end
            ST_STEP_PULSE: begin
                if (halt_i) begin m_st = ST_DRAIN; m_drain_left = DRAIN_CYCLES; end
                else begin m_st = ST_STEP_WAIT; m_ack = 1; end
            end
            ST_DRAIN: begin
                m_drain_left--;
                if (m_drain_left == 0) m_st = ST_DONE;
            end
            default: m_st = ST_IDLE;
        endcase
    endfunction

    function automatic exp_t model_out();
        exp_t x;
        x.en    = (m_st == ST_RUN) || (m_st == ST_STEP_PULSE) || (m_st == ST_DRAIN);
        x.cnt   = m_count[31:0];
        x.cnt_s = (m_count > 15) ? 4'hF : m_count[3:0];
        x.ack   = m_ack;
        x.done  = (m_st == ST_DONE);
        x.busy  = (m_st != ST_IDLE);
        x.st    = m_st;
        return x;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic cycle(input logic rst, input logic st, input logic cv,
                         input logic [7:0] c, input logic h);
        @(negedge clk);
        reset_i = rst; start_i = st; cmd_valid_i = cv; cmd_i = c; halt_i = h;
        model_step();
        exp_q.push_back(model_out());
    endtask

    task automatic idle(input int n, input logic h);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 8'h00, h);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // ---------------- monitor ----------------
    always begin
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("enable_pipe", en_o, e.en);
            chk("count_cycles", cnt_o, e.cnt);
            chk("ack_step", ack_o, e.ack);
            chk("end_exec", end_o, e.done);
            chk("busy", busy_o, e.busy);
            chk("state", st_o, e.st);
            chk("sat_count", cnt_s, e.cnt_s);
            chk("sat_state", st_s, e.st);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] rc;
        reset_i = 1'b1; start_i = 1'b0; cmd_valid_i = 1'b0; cmd_i = 8'h00; halt_i = 1'b0;

        // Reset state
        cycle(1, 0, 0, 8'h00, 0);
        cycle(1, 0, 0, 8'h00, 0);
        settle();
        chk("reset_state", st_o, 0);
        chk("reset_count", cnt_o, 0);
        chk("reset_enable", en_o, 0);

        // Continuous run: HALT sampled at the end of the 10th RUN cycle
        cycle(0, 1, 0, 8'h00, 0);
        cycle(0, 0, 1, CMD_CONT, 0);
        idle(9, 0);
        cycle(0, 0, 0, 8'h00, 1);
        idle(DRAIN_CYCLES, 1);
        settle();
        chk("cont_end_exec", end_o, 1);
        idle(1, 0);
        settle();
        chk("cont_count", cnt_o, 14);
        chk("cont_idle", st_o, 0);

        // Step mode: three 'n' bytes, no halt
        cycle(0, 1, 0, 8'h00, 0);
        cycle(0, 0, 1, CMD_STEP, 0);
        for (int k = 0; k < 3; k++) begin
            idle(19, 0);
            cycle(0, 0, 1, CMD_NEXT, 0);
        end
        idle(4, 0);
        settle();
        chk("step_count", cnt_o, 3);
        chk("step_state", st_o, 3);

        // Step into halt; also 'n' + halt together in STEP_WAIT (command wins)
        cycle(1, 0, 0, 8'h00, 0);
        cycle(0, 1, 0, 8'h00, 0);
        cycle(0, 0, 1, CMD_STEP, 0);
        cycle(0, 0, 1, CMD_NEXT, 0);
        idle(5, 0);
        cycle(0, 0, 1, CMD_NEXT, 1);
        idle(1 + DRAIN_CYCLES, 1);
        settle();
        chk("stephalt_end_exec", end_o, 1);
        chk("stephalt_count", cnt_o, 6);
        idle(2, 0);

        // Invalid / ignored commands
        cycle(0, 1, 0, 8'h00, 0);
        cycle(0, 0, 1, 8'h41, 0);
        settle();
        chk("invalid_in_mode", st_o, 1);
        cycle(0, 0, 1, CMD_CONT, 0);
        cycle(0, 0, 1, CMD_CONT, 0);
        cycle(0, 1, 0, 8'h00, 0);
        settle();
        chk("ignored_in_run", st_o, 2);
        cycle(0, 0, 0, 8'h00, 1);
        idle(DRAIN_CYCLES + 1, 0);
        settle();
        chk("invalid_back_idle", st_o, 0);

        // Reset mid-RUN
        cycle(0, 1, 0, 8'h00, 0);
        cycle(0, 0, 1, CMD_CONT, 0);
        idle(4, 0);
        cycle(1, 0, 0, 8'h00, 0);
        settle();
        chk("midrst_state", st_o, 0);
        chk("midrst_enable", en_o, 0);
        chk("midrst_count", cnt_o, 0);
        chk("midrst_end_exec", end_o, 0);

        // Saturation: 30 RUN cycles before halt
        cycle(0, 1, 0, 8'h00, 0);
        cycle(0, 0, 1, CMD_CONT, 0);
        idle(29, 0);
        cycle(0, 0, 0, 8'h00, 1);
        idle(DRAIN_CYCLES + 1, 0);
        settle();
        chk("sat_narrow_count", cnt_s, 4'hF);
        chk("sat_wide_count", cnt_o, 34);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            case ($urandom_range(0, 3))
                0:       rc = CMD_CONT;
                1:       rc = CMD_STEP;
                2:       rc = CMD_NEXT;
                default: rc = 8'($urandom_range(0, 255));
            endcase
            cycle(($urandom_range(0, 79) == 0),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 3) == 0),
                  rc,
                  ($urandom_range(0, 9) < 2));
        end

        // Let the monitor consume what is left, with a bound
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) chk("queue_drain", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_exec_ctrl.md
Name: pipe_exec_ctrl

Overview:
Execution-mode controller between the debug unit's UART command path and the MIPS pipeline.
- After a program is loaded, it accepts a mode command (continuous or step) and generates `enable_pipe_o` for the pipeline registers and PC.
- On HALT it drains the remaining pipeline stages and reports completion.
- It keeps the executed-cycle count that the debug unit sends to the host.

Parameters:
- N_BITS, 8, width of a UART command byte.
- NB_CYCLES, 32, width of the executed-cycle counter.
- DRAIN_CYCLES, 4, enable cycles issued after HALT is seen (ID/EX/MEM/WB drain).
- NB_STATE, 3, width of the `state_o` debug output.

Ports:
- clock_i  in  1  processor clock (same domain as the pipeline).
- reset_i  in  1  synchronous reset, active-high.
- start_i  in  1  one-cycle pulse from the debug unit: program load finished.
- cmd_valid_i  in  1  one-cycle pulse: `cmd_i` holds a received byte.
- cmd_i  in  N_BITS  command byte.
- halt_i  in  1  HALT fetched (from IF); level, may stay high.
- enable_pipe_o  out  1  pipeline/PC advance enable.
- count_cycles_o  out  NB_CYCLES  enable cycles executed since the last start.
- ack_step_o  out  1  one-cycle pulse: a single step completed.
- end_exec_o  out  1  one-cycle pulse: program finished and pipeline drained.
- busy_o  out  1  high in every state except IDLE.
- state_o  out  NB_STATE  current state encoding (debug).

Behaviour:
- Clocking and reset:
  - One clock, `clock_i`; reset is synchronous and active-high on `reset_i`.
  - Reset, including mid-operation, takes effect at the next edge: state=IDLE, all outputs 0, counter 0, drain counter 0.
- Command codes: CMD_CONT=8'h63 ('c'), CMD_STEP=8'h73 ('s'), CMD_NEXT=8'h6E ('n').
- Output timing:
  - Moore outputs are decoded from the state register.
  - `enable_pipe_o`=1 exactly in RUN, STEP_PULSE and DRAIN.
  - `busy_o` = (state != IDLE).
- States (encoding 0..5): IDLE, MODE, RUN, STEP_WAIT, STEP_PULSE, DRAIN, DONE is 6.
  - IDLE: `start_i` -> MODE and clear `count_cycles_o`. `cmd_valid_i` is ignored.
  - MODE:
    - `cmd_valid_i` & CMD_CONT -> RUN.
    - `cmd_valid_i` & CMD_STEP -> STEP_WAIT.
    - Any other byte is ignored; stay in MODE.
  - RUN:
    - `halt_i`=1 at an edge -> DRAIN, loading the drain counter with DRAIN_CYCLES-1.
    - Otherwise stay. Commands are ignored.
  - STEP_WAIT:
    - `cmd_valid_i` & CMD_NEXT -> STEP_PULSE.
    - `cmd_valid_i` & CMD_CONT -> RUN (mode switch).
    - Otherwise stay. `halt_i` is not acted on here.
  - STEP_PULSE: lasts exactly one cycle.
    - `halt_i`=1 -> DRAIN, loading the drain counter.
    - Else -> STEP_WAIT with `ack_step_o`=1 registered for the first STEP_WAIT cycle.
  - DRAIN:
    - Drain counter 0 -> DONE; else decrement.
    - Exactly DRAIN_CYCLES cycles in DRAIN.
  - DONE: one cycle. `end_exec_o`=1 (Moore), then -> IDLE.
- Cycle counter:
  - Increments at every edge where `enable_pipe_o`=1.
  - Saturates at all-ones; no wrap.
  - Holds its value in IDLE until the next `start_i`.
- Simultaneous events:
  - `start_i` outside IDLE is ignored.
  - `reset_i` dominates everything.
  - Command and halt in the same STEP_WAIT cycle: the command wins (halt is not sampled in STEP_WAIT).
- Latency:
  - From the `cmd_valid_i` edge to `enable_pipe_o`=1 is 1 cycle.
  - From `halt_i` sampled in RUN to `end_exec_o` is DRAIN_CYCLES+1 cycles.

Decomposition:
- Shared package (`parameters.vh` style include): command byte constants and the state encodings, so the debug unit and testbench use the same values.
- One natural sub-module: sat_counter (parameter WIDTH; ports clear, inc, value), used for `count_cycles_o`.
- The drain counter stays inline.

Test Plan:
- Continuous run:
  - Stimulus: `start_i`, then 'c'; `halt_i` rises during the 10th RUN cycle.
  - Response: `count_cycles_o`=14, `enable_pipe_o` high for exactly 14 consecutive cycles, `end_exec_o` a single pulse 5 cycles after the halt edge, then state=IDLE.
- Step mode:
  - Stimulus: `start_i`, 's', then three 'n' bytes spaced 20 cycles apart, no halt.
  - Response: three single-cycle `enable_pipe_o` pulses, three `ack_step_o` pulses each one cycle after its enable, `count_cycles_o`=3, state=STEP_WAIT.
- Step into halt:
  - Stimulus: in step mode, `halt_i`=1 during the second STEP_PULSE.
  - Response: no second `ack_step_o`; DRAIN runs 4 cycles; `count_cycles_o`=6; `end_exec_o` pulses.
- Invalid and ignored commands:
  - Stimulus: 8'h41 in MODE, 'c' during RUN, `start_i` during RUN.
  - Response: state unchanged in each case; 'c' then starts RUN normally from MODE.
- Reset mid-RUN:
  - Stimulus: `reset_i` for one cycle at RUN cycle 5.
  - Response: next cycle state=IDLE, `enable_pipe_o`=0, `count_cycles_o`=0, no `end_exec_o`.
- Saturation:
  - Stimulus: NB_CYCLES=4, run 30 cycles before halt.
  - Response: `count_cycles_o` stays at 4'hF with no wrap.
